// File: rtl/issue_ctrl.sv
`default_nettype none
// ============================================================================
// issue_ctrl : decode->execute issue gate with RAW write scoreboard and
//              branch hold / taken-branch flush of fetch and decode.
// Option     : ISSUE_CTRL_FORWARDING_EN (ALU bypass, single load-use bubble)
// Revision   : 1.0
// ============================================================================
module issue_ctrl #(
  parameter int NREG         = 32,
  parameter int ALU_LAT      = 2,
  parameter int LOAD_LAT     = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_dec_valid,
  input  logic [4:0]      i_dec_rs1,
  input  logic [4:0]      i_dec_rs2,
  input  logic [4:0]      i_dec_rd,
  input  logic            i_dec_uses_rs1,
  input  logic            i_dec_uses_rs2,
  input  logic            i_dec_reg_write,
  input  logic            i_dec_mem_read,
  input  logic            i_dec_branch,
  input  logic            i_ex_resolved,
  input  logic            i_ex_taken,
  output logic            o_issue,
  output logic            o_stall,
  output logic            o_flush,
  output logic [NREG-1:0] o_busy_mask,
  output logic [1:0]      o_state
);

  localparam int CW = $clog2(LOAD_LAT + 1);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_BR_WAIT = 2'd1,
    S_FLUSH   = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_flush;
  logic [FW-1:0]   r_fcnt;
  logic [NREG-1:0] w_busy;
  logic            w_hz;
  logic            w_issue;
  logic            w_stall;
  logic            w_sb_wr;
  logic [CW-1:0]   w_sb_val;

`ifdef ISSUE_CTRL_FORWARDING_EN
  // ALU results are bypassed, so only loads need to hold their consumer off.
  assign w_sb_wr  = w_issue & i_dec_reg_write & i_dec_mem_read & (i_dec_rd != 5'd0);
  assign w_sb_val = CW'(1);
`else
  assign w_sb_wr  = w_issue & i_dec_reg_write & (i_dec_rd != 5'd0);
  assign w_sb_val = i_dec_mem_read ? CW'(LOAD_LAT) : CW'(ALU_LAT);
`endif

  genvar gi;
  for (gi = 0; gi < NREG; gi++) begin : g_sb
    if (gi == 0) begin : g_x0
      assign w_busy[gi] = 1'b0;
    end else begin : g_xn
      logic [CW-1:0] r_cnt;
      // A new writer reloads the counter even if it is mid-countdown.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (w_sb_wr && (i_dec_rd == 5'(gi))) begin
          r_cnt <= w_sb_val;
        end else if (r_cnt != '0) begin
          r_cnt <= r_cnt - CW'(1);
        end
      end
      assign w_busy[gi] = (r_cnt != '0);
    end
  end

  assign w_hz = (i_dec_uses_rs1 & (i_dec_rs1 != 5'd0) & w_busy[i_dec_rs1]) |
                (i_dec_uses_rs2 & (i_dec_rs2 != 5'd0) & w_busy[i_dec_rs2]);

  // rst_n gating keeps issue/stall low for the whole reset window.
  assign w_issue = rst_n & i_dec_valid & ~w_hz & (r_state == S_RUN);
  assign w_stall = rst_n & i_dec_valid & ~w_issue & (r_state != S_FLUSH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_flush <= 1'b0;
      r_fcnt  <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_issue && i_dec_branch) r_state <= S_BR_WAIT;
        end
        S_BR_WAIT: begin
          if (i_ex_resolved) begin
            if (i_ex_taken) begin
              r_state <= S_FLUSH;
              r_flush <= 1'b1;
              r_fcnt  <= FW'(FLUSH_CYCLES);
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_FLUSH: begin
          if (r_fcnt <= FW'(1)) begin
            r_state <= S_RUN;
            r_flush <= 1'b0;
            r_fcnt  <= '0;
          end else begin
            r_fcnt <= r_fcnt - FW'(1);
          end
        end
        default: begin
          r_state <= S_RUN;
          r_flush <= 1'b0;
          r_fcnt  <= '0;
        end
      endcase
    end
  end

  assign o_issue     = w_issue;
  assign o_stall     = w_stall;
  assign o_flush     = r_flush;
  assign o_busy_mask = w_busy;
  assign o_state     = r_state;

endmodule
`default_nettype wire

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Issue/hazard controller between the decode stage and execute.
- Holds a per-register write scoreboard and stalls decode on RAW hazards.
- Holds issue after a branch until execute resolves it; on a taken branch, flushes fetch/decode for a fixed number of cycles.
- Drives the stall/flush inputs of the fetch and decode pipeline registers.

Parameters:
- NREG, 32: number of architectural registers; x0 is never tracked.
- ALU_LAT, 2: cycles from issue until an ALU result is readable from the register bank.
- LOAD_LAT, 3: cycles from issue until load data is readable from the register bank.
- FLUSH_CYCLES, 2: cycles `flush` is held after a taken branch; must be ≥1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dec_valid  in  1  decode holds a valid instruction.
- dec_rs1  in  5  source register 1.
- dec_rs2  in  5  source register 2.
- dec_rd  in  5  destination register.
- dec_uses_rs1  in  1  instruction reads rs1.
- dec_uses_rs2  in  1  instruction reads rs2.
- dec_reg_write  in  1  instruction writes rd.
- dec_mem_read  in  1  instruction is a load.
- dec_branch  in  1  instruction is a branch or jump.
- ex_resolved  in  1  one-cycle pulse: execute resolved the outstanding branch.
- ex_taken  in  1  qualifies ex_resolved: 1 = taken.
- issue  out  1  instruction accepted into execute this cycle.
- stall  out  1  hold the fetch and decode registers.
- flush  out  1  clear the fetch and decode registers.
- busy_mask  out  NREG  bit i set while register i has a pending write.
- state  out  2  0 = RUN, 1 = BR_WAIT, 2 = FLUSH.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - all scoreboard counters 0; busy_mask = 0.
  - state = RUN; flush = 0; flush counter 0.
  - issue = 0 and stall = 0 while reset is held.
  - Reset asserted mid-operation aborts any BR_WAIT/FLUSH immediately.
- Scoreboard:
  - One down-counter per register, width $clog2(LOAD_LAT+1).
  - Each cycle, every nonzero counter decrements by 1.
  - On issue with dec_reg_write = 1 and dec_rd ≠ 0, counter[rd] loads LOAD_LAT if dec_mem_read, else ALU_LAT.
  - When the load and the decrement hit the same register in the same cycle, the load wins.
  - dec_rd = 0 is never marked busy.
  - busy_mask[i] = (counter[i] ≠ 0); busy_mask[0] is always 0.
- Hazard (combinational):
  - hz = (dec_uses_rs1 & rs1 ≠ 0 & busy[rs1]) | (dec_uses_rs2 & rs2 ≠ 0 & busy[rs2]).
  - The scoreboard value checked is the registered value before this cycle's update, so a producer issued in cycle N blocks its consumer from cycle N+1.
- Issue / stall (combinational):
  - issue = dec_valid & ~hz & (state == RUN).
  - stall = dec_valid & ~issue & (state ≠ FLUSH).
- FSM:
  - RUN: issue of an instruction with dec_branch = 1 → BR_WAIT. ex_resolved is ignored in RUN.
  - BR_WAIT: no issue. ex_resolved & ex_taken → FLUSH and load the flush counter with FLUSH_CYCLES. ex_resolved & ~ex_taken → RUN.
  - FLUSH: flush = 1 (registered, high for exactly FLUSH_CYCLES cycles); issue = 0; stall = 0. Counter decrements each cycle; at 1 → RUN.
  - The scoreboard keeps decrementing in every state. It is never cleared by flush, because nothing younger than the branch was issued.
- Latency:
  - issue has zero latency from dec_valid.
  - flush rises on the first edge after a taken ex_resolved.

Optional Feature:
- Macro: ISSUE_CTRL_FORWARDING_EN.
- Defined: execute bypasses ALU results. ALU writes do not update the scoreboard. Loads set counter[rd] = 1 instead of LOAD_LAT, giving exactly one load-use bubble.
- Undefined: full scoreboard timing as described under Behaviour.

Test Plan:
- Reset then release with no dec_valid → busy_mask = 0, state = RUN, issue/stall/flush = 0. Assert rst_n = 0 while in FLUSH → state = RUN and flush = 0 asynchronously.
- Issue ADDI x5 (ALU) in cycle 0; present ADD x6,x5,x5 from cycle 1 → stall = 1 in cycles 1–2, issue = 1 in cycle 3 (ALU_LAT = 2). Forwarding build: issue in cycle 1.
- Issue LW x7 in cycle 0; present a consumer of x7 from cycle 1 → stall for 3 cycles, issue in cycle 4. Forwarding build: one-cycle stall.
- Issue a branch; pulse ex_resolved = 1, ex_taken = 0 two cycles later → BR_WAIT for 2 cycles, back to RUN, no flush.
- Issue a branch; pulse ex_resolved = 1, ex_taken = 1 → flush = 1 for exactly 2 cycles, issue = 0 throughout, then RUN.
- Issue LW x3, then ADDI x3 one cycle later → counter[3] reloads to 2 (last writer wins); busy_mask[3] clears 2 cycles after the ADDI. Writes to rd = x0 never set busy_mask.
